// File: rtl/uart_defs_pkg.sv
// -----------------------------------------------------------------------------
// uart_defs_pkg
// Shared UART definitions used by the TX engine and the future RX stage:
//   - tx_state_t     : 3-bit FSM state encodings for the transmit engine
//   - BPS_DIV_9600   : clock divisor for 9600 baud at 50 MHz
//   - BPS_DIV_115200 : clock divisor for 115200 baud at 50 MHz
//   - LINE_IDLE      : level of the serial line when nothing is sent
//   - calc_parity()  : parity bit of a byte, even or odd
// -----------------------------------------------------------------------------
package uart_defs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } tx_state_t;

  localparam int unsigned BPS_DIV_9600   = 5208;
  localparam int unsigned BPS_DIV_115200 = 434;

  localparam logic LINE_IDLE = 1'b1;

  // Even parity makes the total count of ones even; odd parity inverts it.
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bps_tick.sv
// -----------------------------------------------------------------------------
// uart_bps_tick
// Bit-period timer. A 16-bit counter runs 0..BPS_DIV-1 while run is high and
// is held at zero while run is low. tick pulses for one cycle on the last
// count of each bit period, on the same cycle the counter wraps.
// Ports:
//   CLK   in  system clock
//   RST_N in  asynchronous active-low reset
//   run   in  counter enable; low clears the counter
//   tick  out one-cycle pulse at the end of each bit period
// -----------------------------------------------------------------------------
module uart_bps_tick #(
  parameter int unsigned BPS_DIV = 5208
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic run,
  output logic tick
);

  localparam logic [15:0] LAST_CNT = 16'(BPS_DIV - 1);

  logic [15:0] r_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (!run) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST_CNT) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign tick = run && (r_cnt == LAST_CNT);

endmodule

// File: rtl/uart_tx_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_engine
// UART transmit serialiser. On a level enable it latches a byte and sends
// start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits,
// and returns a one-cycle done pulse so the control stage can drop enable.
// Ports:
//   CLK         in  system clock
//   RST_N       in  asynchronous active-low reset (aborts any frame silently)
//   TX_En_Sig   in  level request, held until TX_Done_Sig is seen
//   TX_Data     in  byte to send, sampled only on the frame-start edge
//   TX_Done_Sig out one-cycle pulse when the last stop bit completes
//   TX_Busy     out high from frame start through the done cycle
//   TX_Pin_Out  out serial line, idles high
// All outputs are registered.
// -----------------------------------------------------------------------------
module uart_tx_engine
  import uart_defs_pkg::*;
#(
  parameter int unsigned BPS_DIV    = BPS_DIV_9600,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       TX_En_Sig,
  input  logic [7:0] TX_Data,
  output logic       TX_Done_Sig,
  output logic       TX_Busy,
  output logic       TX_Pin_Out
);

  // Index of the final stop bit: 0 for one stop bit, 1 for two.
  localparam logic LAST_STOP = (STOP_BITS == 2);
  localparam logic ODD_PAR   = (PARITY_ODD != 0);
  localparam logic HAS_PAR   = (PARITY_EN != 0);

  tx_state_t  r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bit_idx;
  logic       r_parity;
  logic       r_stop_cnt;

  logic       w_run;
  logic       w_tick;

  // The bit timer only runs while a bit is actually on the line.
  assign w_run = (r_state != ST_IDLE) && (r_state != ST_DONE);

  uart_bps_tick #(
    .BPS_DIV (BPS_DIV)
  ) u_bps_tick (
    .CLK   (CLK),
    .RST_N (RST_N),
    .run   (w_run),
    .tick  (w_tick)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_parity    <= 1'b0;
      r_stop_cnt  <= 1'b0;
      TX_Pin_Out  <= LINE_IDLE;
      TX_Done_Sig <= 1'b0;
      TX_Busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          TX_Pin_Out  <= LINE_IDLE;
          TX_Done_Sig <= 1'b0;
          TX_Busy     <= 1'b0;
          if (TX_En_Sig) begin
            // Parity is taken from the byte now, before it is shifted out.
            r_shift    <= TX_Data;
            r_parity   <= calc_parity(TX_Data, ODD_PAR);
            TX_Pin_Out <= 1'b0;
            TX_Busy    <= 1'b1;
            r_state    <= ST_START;
          end
        end

        ST_START: begin
          if (w_tick) begin
            TX_Pin_Out <= r_shift[0];
            r_shift    <= {1'b0, r_shift[7:1]};
            r_bit_idx  <= 3'd0;
            r_state    <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (w_tick) begin
            if (r_bit_idx != 3'd7) begin
              r_bit_idx  <= r_bit_idx + 3'd1;
              TX_Pin_Out <= r_shift[0];
              r_shift    <= {1'b0, r_shift[7:1]};
            end else if (HAS_PAR) begin
              TX_Pin_Out <= r_parity;
              r_state    <= ST_PARITY;
            end else begin
              TX_Pin_Out <= 1'b1;
              r_stop_cnt <= 1'b0;
              r_state    <= ST_STOP;
            end
          end
        end

        ST_PARITY: begin
          if (w_tick) begin
            TX_Pin_Out <= 1'b1;
            r_stop_cnt <= 1'b0;
            r_state    <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (w_tick) begin
            if (r_stop_cnt == LAST_STOP) begin
              TX_Done_Sig <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          // Enable may still be high here; the new frame waits for IDLE.
          TX_Pin_Out  <= LINE_IDLE;
          TX_Done_Sig <= 1'b0;
          TX_Busy     <= 1'b0;
          r_state     <= ST_IDLE;
        end

        default: begin
          TX_Pin_Out  <= LINE_IDLE;
          TX_Done_Sig <= 1'b0;
          TX_Busy     <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_engine
// Directed bench for uart_tx_engine with BPS_DIV=4. Four instances cover the
// frame formats: 8N1, 8E1, 8O1 and 8E2. Outputs are sampled on the falling
// edge; sample k of a frame is the cycle following start edge + k.
// -----------------------------------------------------------------------------
module tb_uart_tx_engine;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic [3:0] en;
  logic [3:0] pin;
  logic [3:0] done;
  logic [3:0] busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_engine #(.BPS_DIV(DIV), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .CLK(clk), .RST_N(rst_n), .TX_En_Sig(en[0]), .TX_Data(data),
    .TX_Done_Sig(done[0]), .TX_Busy(busy[0]), .TX_Pin_Out(pin[0]));

  uart_tx_engine #(.BPS_DIV(DIV), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .TX_En_Sig(en[1]), .TX_Data(data),
    .TX_Done_Sig(done[1]), .TX_Busy(busy[1]), .TX_Pin_Out(pin[1]));

  uart_tx_engine #(.BPS_DIV(DIV), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
    .CLK(clk), .RST_N(rst_n), .TX_En_Sig(en[2]), .TX_Data(data),
    .TX_Done_Sig(done[2]), .TX_Busy(busy[2]), .TX_Pin_Out(pin[2]));

  uart_tx_engine #(.BPS_DIV(DIV), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
    .CLK(clk), .RST_N(rst_n), .TX_En_Sig(en[3]), .TX_Data(data),
    .TX_Done_Sig(done[3]), .TX_Busy(busy[3]), .TX_Pin_Out(pin[3]));

  // Line level during bit period b of a frame; par is the hand-computed parity.
  function automatic logic exp_bit(input logic [7:0] d, input logic par,
                                   input logic pe, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9 && pe) return par;
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 4'h0;
    data  = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if (pin !== 4'hF) begin errors++; $display("FAIL reset_pin: got %b expected 1111", pin); end
    checks++;
    if (done !== 4'h0) begin errors++; $display("FAIL reset_done: got %b expected 0000", done); end
    checks++;
    if (busy !== 4'h0) begin errors++; $display("FAIL reset_busy: got %b expected 0000", busy); end
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      checks++;
      if (pin !== 4'hF || busy !== 4'h0 || done !== 4'h0) begin
        errors++;
        $display("FAIL idle_after_reset cyc %0d: pin=%b busy=%b done=%b expected 1111/0000/0000",
                 k, pin, busy, done);
      end
    end
  endtask

  task automatic test_frame_8n1();
    logic e;
    data  = 8'h31;
    en[0] = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      e = (k < 40) ? exp_bit(8'h31, 1'b0, 1'b0, k / DIV) : 1'b1;
      checks++;
      if (pin[0] !== e) begin errors++; $display("FAIL 8n1_line cyc %0d: got %b expected %b", k, pin[0], e); end
      checks++;
      if (done[0] !== (k == 40)) begin errors++; $display("FAIL 8n1_done cyc %0d: got %b expected %b", k, done[0], (k == 40)); end
      checks++;
      if (busy[0] !== 1'b1) begin errors++; $display("FAIL 8n1_busy cyc %0d: got %b expected 1", k, busy[0]); end
      if (k == 40) en[0] = 1'b0;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (pin[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
        errors++;
        $display("FAIL 8n1_no_second_frame cyc %0d: pin=%b busy=%b done=%b expected 1/0/0",
                 k, pin[0], busy[0], done[0]);
      end
    end
  endtask

  task automatic test_parity();
    logic e;
    logic par;
    int   n;
    data = 8'h31;
    for (int i = 1; i <= 3; i++) begin
      // 0x31 has three ones: even parity bit 1, odd parity bit 0.
      par = (i == 2) ? 1'b0 : 1'b1;
      n   = (i == 3) ? 48 : 44;
      en[i] = 1'b1;
      for (int k = 0; k <= n; k++) begin
        @(negedge clk);
        e = (k < n) ? exp_bit(8'h31, par, 1'b1, k / DIV) : 1'b1;
        checks++;
        if (pin[i] !== e) begin errors++; $display("FAIL parity%0d_line cyc %0d: got %b expected %b", i, k, pin[i], e); end
        checks++;
        if (done[i] !== (k == n)) begin errors++; $display("FAIL parity%0d_done cyc %0d: got %b expected %b", i, k, done[i], (k == n)); end
        checks++;
        if (busy[i] !== 1'b1) begin errors++; $display("FAIL parity%0d_busy cyc %0d: got %b expected 1", i, k, busy[i]); end
        if (k == n) en[i] = 1'b0;
      end
      repeat (4) begin
        @(negedge clk);
        checks++;
        if (busy[i] !== 1'b0 || done[i] !== 1'b0 || pin[i] !== 1'b1) begin
          errors++;
          $display("FAIL parity%0d_idle: pin=%b busy=%b done=%b expected 1/0/0", i, pin[i], busy[i], done[i]);
        end
      end
    end
  endtask

  task automatic test_midframe_change();
    logic e;
    data  = 8'h31;
    en[0] = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      e = (k < 40) ? exp_bit(8'h31, 1'b0, 1'b0, k / DIV) : 1'b1;
      checks++;
      if (pin[0] !== e) begin errors++; $display("FAIL midchg_line cyc %0d: got %b expected %b", k, pin[0], e); end
      checks++;
      if (done[0] !== (k == 40)) begin errors++; $display("FAIL midchg_done cyc %0d: got %b expected %b", k, done[0], (k == 40)); end
      // Data bit 2 occupies samples 12..15.
      if (k == 13) begin
        data  = 8'hA5;
        en[0] = 1'b0;
      end
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
        errors++;
        $display("FAIL midchg_idle cyc %0d: busy=%b done=%b expected 0/0", k, busy[0], done[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    int   r;
    int   ndone = 0;
    data  = 8'h55;
    en[0] = 1'b1;
    // Frame period: 40 bit cycles + DONE + one IDLE cycle.
    for (int k = 0; k < 126; k++) begin
      @(negedge clk);
      r = k % 42;
      e = (r < 40) ? exp_bit(8'h55, 1'b0, 1'b0, r / DIV) : 1'b1;
      if (done[0] === 1'b1) ndone++;
      checks++;
      if (pin[0] !== e) begin errors++; $display("FAIL b2b_line cyc %0d: got %b expected %b", k, pin[0], e); end
      checks++;
      if (done[0] !== (r == 40)) begin errors++; $display("FAIL b2b_done cyc %0d: got %b expected %b", k, done[0], (r == 40)); end
      checks++;
      if (busy[0] !== (r <= 40)) begin errors++; $display("FAIL b2b_busy cyc %0d: got %b expected %b", k, busy[0], (r <= 40)); end
      if (k == 124) en[0] = 1'b0;
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done[0] === 1'b1) ndone++;
      checks++;
      if (pin[0] !== 1'b1 || busy[0] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_idle cyc %0d: pin=%b busy=%b expected 1/0", k, pin[0], busy[0]);
      end
    end
    checks++;
    if (ndone != 3) begin errors++; $display("FAIL b2b_done_count: got %0d expected 3", ndone); end
  endtask

  task automatic test_reset_midframe();
    logic e;
    data  = 8'h31;
    en[0] = 1'b1;
    // Data bit 3 occupies samples 16..19; its value for 0x31 is 0.
    for (int k = 0; k <= 17; k++) begin
      @(negedge clk);
      e = exp_bit(8'h31, 1'b0, 1'b0, k / DIV);
      checks++;
      if (pin[0] !== e) begin errors++; $display("FAIL rstmid_pre_line cyc %0d: got %b expected %b", k, pin[0], e); end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (pin[0] !== 1'b1) begin errors++; $display("FAIL rstmid_async_pin: got %b expected 1", pin[0]); end
    checks++;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL rstmid_async_busy: got %b expected 0", busy[0]); end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (pin[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_hold: pin=%b busy=%b done=%b expected 1/0/0", pin[0], busy[0], done[0]);
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      e = (k < 40) ? exp_bit(8'h31, 1'b0, 1'b0, k / DIV) : 1'b1;
      checks++;
      if (pin[0] !== e) begin errors++; $display("FAIL rstmid_fresh_line cyc %0d: got %b expected %b", k, pin[0], e); end
      checks++;
      if (done[0] !== (k == 40)) begin errors++; $display("FAIL rstmid_fresh_done cyc %0d: got %b expected %b", k, done[0], (k == 40)); end
      if (k == 40) en[0] = 1'b0;
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_idle: busy=%b done=%b expected 0/0", busy[0], done[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_8n1();
    test_parity();
    test_midframe_change();
    test_back_to_back();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
